// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the generic pipeline stage register.
//   pipe_state_t : occupancy of a stage register (EMPTY / ONE / TWO entries)
//   RV32I_NOP    : addi x0,x0,0 -- the bubble payload when the datapath is an instruction
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : add one this cycle (ignored once all ones)
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (inc && (cnt_q != '1))  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable pipeline stage register (replaces fixed IF/ID, ID/EX,
// EX/MEM, MEM/WB registers) with valid/ready handshake, optional 2-entry skid,
// flush with bubble injection and a saturating back-pressure counter.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : upstream handshake; in_data/in_ctrl payload
//   flush               : synchronous kill of every held entry
//   out_valid/out_ready : downstream handshake; out_data/out_ctrl payload
//                         (out_ctrl is forced to zero on a bubble)
//   stall_cnt/stall_clr : cycles with out_valid && !out_ready, saturating; clear
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 CTRL_W     = 8,
  parameter logic [DATA_W-1:0]  FLUSH_DATA = DATA_W'(RV32I_NOP),
  parameter int                 SKID       = 1,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  pipe_state_t       state_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic              fire_in, fire_out;

  // Skid mode decodes ready from state only, which breaks the out_ready ->
  // in_ready timing path. Without skid, a full register can still accept when
  // it is being drained the same cycle. Both are held low during reset.
  generate
    if (SKID != 0) begin : g_skid_rdy
      assign in_ready = rst_n && (state_q != TWO);
    end else begin : g_pass_rdy
      assign in_ready = rst_n && ((state_q == EMPTY) || out_ready);
    end
  endgenerate

  assign out_valid = (state_q != EMPTY);
  assign fire_in   = in_valid  && in_ready;
  assign fire_out  = out_valid && out_ready;

  assign out_data  = main_data_q;
  // Main ctrl keeps its last value after a drain; gate it so downstream write
  // enables never see a stale control word on a bubble.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= FLUSH_DATA;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      // Any entry offered this cycle is dropped; the current head may still
      // have been consumed downstream, which needs no action here.
      state_q     <= EMPTY;
      main_data_q <= FLUSH_DATA;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (fire_in) begin
            state_q     <= ONE;
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end
        end
        ONE: begin
          if (fire_in && fire_out) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (fire_out) begin
            state_q <= EMPTY;
          end else if (fire_in && (SKID != 0)) begin
            // Head is stalled: park the new entry behind it.
            state_q     <= TWO;
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
          end
        end
        TWO: begin
          if (fire_out) begin
            state_q     <= ONE;
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .clr   (stall_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: SKID=1, CNT_W=16
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_stall_clr;
  logic [31:0] a_in_data, a_out_data;
  logic [7:0]  a_in_ctrl, a_out_ctrl;
  logic [15:0] a_stall_cnt;

  // Instance B: SKID=1, CNT_W=4 (saturation)
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_stall_clr;
  logic [31:0] b_in_data, b_out_data;
  logic [7:0]  b_in_ctrl, b_out_ctrl;
  logic [3:0]  b_stall_cnt;

  // Instance C: SKID=0
  logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_stall_clr;
  logic [31:0] c_in_data, c_out_data;
  logic [7:0]  c_in_ctrl, c_out_ctrl;
  logic [15:0] c_stall_cnt;

  pipe_stage_reg #(.SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt), .stall_clr(a_stall_clr));

  pipe_stage_reg #(.SKID(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt), .stall_clr(b_stall_clr));

  pipe_stage_reg #(.SKID(0), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_ctrl(c_in_ctrl), .flush(c_flush),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_ctrl(c_out_ctrl), .stall_cnt(c_stall_cnt), .stall_clr(c_stall_clr));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_in_ctrl = '0; a_flush = 0; a_out_ready = 1; a_stall_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_in_ctrl = '0; b_flush = 0; b_out_ready = 1; b_stall_clr = 0;
    c_in_valid = 0; c_in_data = '0; c_in_ctrl = '0; c_flush = 0; c_out_ready = 1; c_stall_clr = 0;
    repeat (2) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", a_in_ready); end
    checks++; if (a_out_data !== 32'h13) begin errors++; $display("FAIL rst_out_data got %h exp 00000013", a_out_data); end
    checks++; if (a_out_ctrl !== 8'h0) begin errors++; $display("FAIL rst_out_ctrl got %h exp 00", a_out_ctrl); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", a_stall_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", a_in_ready); end
  endtask

  task automatic test_streaming();
    a_out_ready = 1; a_in_valid = 1;
    a_in_data = 32'h100; a_in_ctrl = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h100 + 32'(4*i) || a_out_ctrl !== 8'(i+1))
        begin errors++; $display("FAIL stream_%0d got v=%b d=%h c=%h exp v=1 d=%h c=%h",
          i, a_out_valid, a_out_data, a_out_ctrl, 32'h100 + 32'(4*i), 8'(i+1)); end
      a_in_data = 32'h104 + 32'(4*i); a_in_ctrl = 8'(i+2);
    end
    a_in_valid = 0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h0) begin errors++;
      $display("FAIL stream_drain got v=%b c=%h exp v=0 c=00", a_out_valid, a_out_ctrl); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_cnt got %0d exp 0", a_stall_cnt); end
  endtask

  task automatic test_backpressure();
    a_in_valid = 1; a_in_data = 32'h200; a_in_ctrl = 8'h20; a_out_ready = 0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h200 || a_in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_one got v=%b d=%h r=%b exp v=1 d=200 r=1", a_out_valid, a_out_data, a_in_ready); end
    a_in_data = 32'h204; a_in_ctrl = 8'h21;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0 || a_stall_cnt !== 16'd1) begin errors++;
      $display("FAIL bp_two got r=%b cnt=%0d exp r=0 cnt=1", a_in_ready, a_stall_cnt); end
    a_in_data = 32'h208; a_in_ctrl = 8'h22;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0 || a_stall_cnt !== 16'd2) begin errors++;
      $display("FAIL bp_hold got r=%b cnt=%0d exp r=0 cnt=2", a_in_ready, a_stall_cnt); end
    @(negedge clk);
    checks++; if (a_stall_cnt !== 16'd3 || a_out_data !== 32'h200 || a_out_ctrl !== 8'h20) begin errors++;
      $display("FAIL bp_cnt got cnt=%0d d=%h c=%h exp cnt=3 d=200 c=20", a_stall_cnt, a_out_data, a_out_ctrl); end
    a_out_ready = 1; a_in_valid = 0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h204 || a_out_ctrl !== 8'h21 || a_in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_drain1 got v=%b d=%h c=%h r=%b exp v=1 d=204 c=21 r=1",
        a_out_valid, a_out_data, a_out_ctrl, a_in_ready); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd3) begin errors++;
      $display("FAIL bp_drain2 got v=%b cnt=%0d exp v=0 cnt=3", a_out_valid, a_stall_cnt); end
  endtask

  task automatic test_flush_collide();
    a_in_valid = 1; a_in_data = 32'h300; a_in_ctrl = 8'h30; a_out_ready = 0;
    @(negedge clk);
    a_in_data = 32'h304; a_in_ctrl = 8'h31;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0 || a_out_data !== 32'h300) begin errors++;
      $display("FAIL fl_two got r=%b d=%h exp r=0 d=300", a_in_ready, a_out_data); end
    a_flush = 1; a_in_data = 32'h308; a_in_ctrl = 8'h32;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h0 || a_out_data !== 32'h13 || a_in_ready !== 1'b1)
      begin errors++; $display("FAIL fl_bubble got v=%b c=%h d=%h r=%b exp v=0 c=00 d=00000013 r=1",
        a_out_valid, a_out_ctrl, a_out_data, a_in_ready); end
    checks++; if (a_stall_cnt !== 16'd5) begin errors++; $display("FAIL fl_cnt got %0d exp 5", a_stall_cnt); end
    // Flush against an accepted input in ONE: the input is dropped.
    a_flush = 0; a_in_data = 32'h400; a_in_ctrl = 8'h40;
    @(negedge clk);
    a_flush = 1; a_in_data = 32'h404; a_in_ctrl = 8'h41;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fl_one_rdy got %b exp 1", a_in_ready); end
    @(negedge clk);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h13) begin errors++;
      $display("FAIL fl_one got v=%b d=%h exp v=0 d=00000013", a_out_valid, a_out_data); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped got v=%b exp 0", a_out_valid); end
    a_stall_clr = 1;
    @(negedge clk);
    a_stall_clr = 0;
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL a_clr got %0d exp 0", a_stall_cnt); end
  endtask

  task automatic test_saturation();
    b_in_valid = 1; b_in_data = 32'h55; b_in_ctrl = 8'h5; b_out_ready = 0;
    @(negedge clk);
    b_in_valid = 0;
    repeat (5) @(negedge clk);
    checks++; if (b_stall_cnt !== 4'd5) begin errors++; $display("FAIL sat_mid got %0d exp 5", b_stall_cnt); end
    repeat (15) @(negedge clk);
    checks++; if (b_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_top got %0d exp 15", b_stall_cnt); end
    b_stall_clr = 1;
    @(negedge clk);
    checks++; if (b_stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", b_stall_cnt); end
    b_stall_clr = 0;
    @(negedge clk);
    checks++; if (b_stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_restart got %0d exp 1", b_stall_cnt); end
  endtask

  task automatic test_noskid();
    c_in_valid = 1; c_in_data = 32'h500; c_in_ctrl = 8'h50; c_out_ready = 1;
    #1;
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL ns_empty_rdy got %b exp 1", c_in_ready); end
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 32'h500) begin errors++;
      $display("FAIL ns_first got v=%b d=%h exp v=1 d=500", c_out_valid, c_out_data); end
    c_in_data = 32'h504; c_in_ctrl = 8'h51; c_out_ready = 0;
    #1;
    checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL ns_full_rdy got %b exp 0", c_in_ready); end
    c_out_ready = 1;
    #1;
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL ns_comb_rdy got %b exp 1", c_in_ready); end
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b1 || c_out_data !== 32'h504 || c_out_ctrl !== 8'h51) begin errors++;
      $display("FAIL ns_replace got v=%b d=%h c=%h exp v=1 d=504 c=51", c_out_valid, c_out_data, c_out_ctrl); end
    c_in_valid = 0;
    @(negedge clk);
    checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL ns_drain got v=%b exp 0", c_out_valid); end
  endtask

  task automatic test_async_reset();
    a_in_valid = 1; a_in_data = 32'h600; a_in_ctrl = 8'h60; a_out_ready = 0;
    @(negedge clk);
    a_in_data = 32'h604; a_in_ctrl = 8'h61;
    @(negedge clk);
    a_in_valid = 0;
    checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_stall_cnt !== 16'd1) begin errors++;
      $display("FAIL ar_pre got v=%b r=%b cnt=%0d exp v=1 r=0 cnt=1", a_out_valid, a_in_ready, a_stall_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_stall_cnt !== 16'd0 || a_out_ctrl !== 8'h0)
      begin errors++; $display("FAIL ar_held got v=%b r=%b cnt=%0d c=%h exp v=0 r=0 cnt=0 c=00",
        a_out_valid, a_in_ready, a_stall_cnt, a_out_ctrl); end
    checks++; if (b_stall_cnt !== 4'd0) begin errors++; $display("FAIL ar_b_cnt got %0d exp 0", b_stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h13 || a_in_ready !== 1'b1) begin errors++;
      $display("FAIL ar_post got v=%b d=%h r=%b exp v=0 d=00000013 r=1", a_out_valid, a_out_data, a_in_ready); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_collide();
    test_saturation();
    test_noskid();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers into one reusable block. It adds a valid/ready handshake, an optional two-entry skid buffer, synchronous flush with bubble injection, and a saturating back-pressure counter. It sits between any two pipeline stages:

- the upstream stage drives `in_*`;
- the downstream stage consumes `out_*`;
- the hazard unit drives `flush`.

## Interface
Parameters:
- `DATA_W`, 32: width of the datapath payload (PC, instruction, operands, immediates).
- `CTRL_W`, 8: width of the control payload (RegWrite, MemRead, MemWrite, ALUOp, …). It is forced to zero whenever the output is a bubble.
- `FLUSH_DATA`, 32'h00000013: value loaded into `out_data` on reset and flush (the RV32I NOP when the payload is an instruction).
- `SKID`, 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `in_valid`  in  1: upstream payload valid.
- `in_ready`  out  1: the block accepts the payload this cycle.
- `in_data`  in  DATA_W: upstream datapath payload.
- `in_ctrl`  in  CTRL_W: upstream control payload.
- `flush`  in  1: synchronous kill of all held entries.
- `out_valid`  out  1: the output entry is valid.
- `out_ready`  in  1: downstream consumes the output this cycle.
- `out_data`  out  DATA_W: held datapath payload.
- `out_ctrl`  out  CTRL_W: held control payload; all zeros when `out_valid`=0.
- `stall_cnt`  out  CNT_W: saturating count of cycles with `out_valid && !out_ready`.
- `stall_clr`  in  1: synchronous clear of `stall_cnt`.

## Operation
- Handshake events:
  - `fire_in` = `in_valid && in_ready`.
  - `fire_out` = `out_valid && out_ready`.
- `out_valid` = (state != EMPTY).
- States are EMPTY, ONE and TWO; TWO exists only when `SKID`=1. The main register drives `out_*`; the skid register holds the second entry.
- EMPTY:
  - `fire_in` → ONE, main ← in.
- ONE:
  - `fire_in && fire_out` → ONE, main ← in.
  - `fire_out` only → EMPTY.
  - `fire_in` only → TWO, skid ← in.
  - no event → ONE, hold.
- TWO:
  - `fire_out` → ONE, main ← skid.
  - no `fire_out` → hold.
  - `in_ready`=0, so `fire_in` cannot occur.
- `in_ready`:
  - `SKID`=1: `in_ready` = (state != TWO), decoded from the state register only, so there is no combinational path from `out_ready`.
  - `SKID`=0: `in_ready` = (state==EMPTY) || `out_ready`.
  - In both modes `in_ready` is gated to 0 while `rst_n`=0.
- Flush:
  - Next state → EMPTY.
  - main data ← `FLUSH_DATA`; main ctrl ← 0; the skid entry is discarded.
  - Flush takes priority over a simultaneous `fire_in` (that input is dropped) and over `fire_out` (the downstream handshake is still honoured for the current cycle's data).
- Bubble rule: when `out_valid`=0, `out_ctrl` is all zeros and `out_data` is `FLUSH_DATA` or the last flushed/held value. Downstream write enables therefore never assert on a bubble.
- Stall counter:
  - Increments by 1 each cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1 with no wrap.
  - `stall_clr` takes priority over increment.
  - `flush` does not clear it.

## Timing
- Reset (asynchronous, takes effect while `rst_n`=0):
  - state EMPTY, `out_valid`=0, `out_data`=`FLUSH_DATA`, `out_ctrl`=0, `stall_cnt`=0, `in_ready`=0.
  - In the first cycle after release, `in_ready`=1.
- Latency: `fire_in` in cycle N → `out_valid`=1 with that payload in cycle N+1.
- Throughput: 1 entry per cycle when `out_ready` is held high.
- `SKID`=1: after `out_ready` drops, at most one further entry is accepted. `in_ready` falls in the cycle after entering TWO. No entry is lost or duplicated.
- Flush asserted in cycle N → `out_valid`=0 from cycle N+1; `in_ready`=1 in cycle N+1.
- Reset mid-operation: all entries lost; no partial payload appears after reset release.

## Structure
- Package `pipe_pkg`:
  - state enum `pipe_state_t` {EMPTY, ONE, TWO};
  - constant `RV32I_NOP` = 32'h00000013, used as the `FLUSH_DATA` default.
- Sub-module `pipe_sat_counter` (parameter `CNT_W`; ports `clk`, `rst_n`, `inc`, `clr`, `cnt`) implements the stall counter.
- Legacy stage registers become thin instances with `DATA_W`/`CTRL_W` sized to their bundles.

## Test plan
- Reset then streaming:
  - Stimulus: release `rst_n`; drive `in_data` 0x100, 0x104, 0x108 on consecutive cycles with `out_ready`=1.
  - Required response: `out_data` presents the same sequence one cycle later; `stall_cnt`=0.
- Back-pressure with `SKID`=1:
  - Stimulus: hold `out_ready`=0 for 3 cycles while `in_valid`=1.
  - Required response: exactly 2 entries held; `in_ready`=0 from the third cycle; `stall_cnt`=3.
  - Then, on release of `out_ready`: both entries drain in order and none is lost.
- Flush colliding with accept:
  - Stimulus: state TWO, `flush`=1 and `in_valid`=1 in the same cycle.
  - Required response: next cycle `out_valid`=0, `out_ctrl`=0, `out_data`=0x00000013; the incoming entry is dropped.
- Counter saturation:
  - Stimulus: `CNT_W`=4; stall for 20 cycles.
  - Required response: `stall_cnt`=15; `stall_clr` → 0 the next cycle.
- `SKID`=0 mode:
  - Stimulus: state ONE with `out_ready`=1 and `in_valid`=1.
  - Required response: `in_ready`=1 in the same cycle (combinational path), and the new payload replaces the old one.
- Asynchronous reset mid-stall:
  - Stimulus: assert `rst_n`=0 in state TWO.
  - Required response: `out_valid` drops immediately and `in_ready`=0 while reset is held; `stall_cnt`=0.
